// File: rtl/stage50_pkg.sv
// Shared types for the router output stage: the flit type lives in `types`,
// stage-local constants in stage50_pkg.
package types;
   localparam int FLIT_W = 32;
   typedef logic [FLIT_W-1:0] flit_t;
endpackage

package stage50_pkg;
   localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/stage50_flit_fifo.sv
// Flit storage for stage50: circular buffer with natural pointer wrap and an
// explicit occupancy counter so full and empty are distinguishable.
module flit_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  types::flit_t                 wdata,
   output types::flit_t                 rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   types::flit_t    mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; stale entries are never visible past count.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

endmodule

// File: rtl/stage50.sv
// Router output buffering stage: FIFO toward the transmitter with almost-full
// and overflow reporting. Define STAGE50_DROP_COUNTER_EN to add out_drop_count.
module stage50
   import stage50_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int ALMOST_FULL_TH = 6
) (
   input  logic                         nocclk,
   input  logic                         rst_n,
   input  logic                         in_flit_valid,
   input  types::flit_t                 in_flit,
   input  logic                         in_tx_ready,
   output logic                         out_flit_valid,
   output types::flit_t                 out_flit,
   output logic                         out_almost_full,
   output logic                         out_overflow,
   output logic [$clog2(DEPTH+1)-1:0]   out_count
`ifdef STAGE50_DROP_COUNTER_EN
   ,
   output logic [DROP_CNT_W-1:0]        out_drop_count
`endif
);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] TH_C = CW'(ALMOST_FULL_TH);

   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic          drop;
   types::flit_t  head;

   // Transmitter-facing signals depend only on registered FIFO state.
   assign out_flit_valid  = !empty;
   assign out_flit        = empty ? '0 : head;
   assign out_almost_full = (out_count >= TH_C);

   assign pop  = out_flit_valid && in_tx_ready;
   assign push = in_flit_valid && (!full || pop);
   assign drop = in_flit_valid && full && !pop;

   flit_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (nocclk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (in_flit),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (out_count)
   );

   always_ff @(posedge nocclk) begin
      if (!rst_n)
         out_overflow <= 1'b0;
      else
         out_overflow <= drop;
   end

`ifdef STAGE50_DROP_COUNTER_EN
   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   // Advances on the same edge that raises out_overflow.
   always_ff @(posedge nocclk) begin
      if (!rst_n)
         out_drop_count <= '0;
      else if (drop)
         out_drop_count <= sat_inc(out_drop_count);
   end
`endif

endmodule
